// File: rtl/fog_demod_pkg.sv
// Shared state encoding, minimum half-period and default widths for the
// fog_demod_accum square-wave modulator / synchronous demodulator.
package fog_demod_pkg;

    localparam int DEF_ADC_W = 14;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_ERR_W = 32;
    localparam int FREQ_MIN  = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POS  = 2'd1,
        S_NEG  = 2'd2
    } state_t;

endpackage

// File: rtl/fog_mod_timer.sv
// Half-period timer: latches (and clamps) the half-period / settling-skip
// configuration at period boundaries and flags half end, period end and accumulate window.
module fog_mod_timer
    import fog_demod_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  state_t           i_state,
    input  logic [CNT_W-1:0] i_freq_cnt,
    input  logic [CNT_W-1:0] i_wait_cnt,
    output logic             o_half_end,
    output logic             o_period_end,
    output logic             o_acc_en,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] C_FMIN = CNT_W'(FREQ_MIN);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_freq;
    logic [CNT_W-1:0] r_wait;
    logic [CNT_W-1:0] w_freq_clamped;
    logic             w_active;

    assign w_freq_clamped = (i_freq_cnt < C_FMIN) ? C_FMIN : i_freq_cnt;
    assign w_active       = (i_state == S_POS) || (i_state == S_NEG);
    assign o_half_end     = w_active && (r_cnt == r_freq - C_ONE);
    assign o_period_end   = o_half_end && (i_state == S_NEG);
    assign o_acc_en       = w_active && (r_cnt >= r_wait);
    assign o_cnt          = r_cnt;

    // Config is sampled only on IDLE exit and at period end, so mid-period
    // changes wait for the next positive half.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_freq <= '0;
            r_wait <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (!w_active || o_period_end) begin
            r_freq <= w_freq_clamped;
            r_wait <= i_wait_cnt;
            r_cnt  <= '0;
        end else if (o_half_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule

// File: rtl/fog_demod_accum.sv
// PIG-loop square-wave modulator and synchronous demodulator: one signed
// error word (sum_pos - sum_neg) per modulation period. Monitor ports: FOG_DEMOD_MONITOR_EN.
module fog_demod_accum
    import fog_demod_pkg::*;
#(
    parameter int ADC_W = DEF_ADC_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ERR_W = DEF_ERR_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic [CNT_W-1:0]        i_freq_cnt,
    input  logic [CNT_W-1:0]        i_wait_cnt,
    input  logic signed [ADC_W-1:0] i_adc,
    output logic                    o_mod_stat,
    output logic signed [ERR_W-1:0] o_err,
    output logic                    o_err_strobe
`ifdef FOG_DEMOD_MONITOR_EN
    ,
    output logic [1:0]              m_state,
    output logic [CNT_W-1:0]        m_cnt,
    output logic [ERR_W-1:0]        m_sum_pos,
    output logic [ERR_W-1:0]        m_sum_neg
`endif
);

    state_t                  r_state;
    logic signed [ERR_W-2:0] r_sum_pos;
    logic signed [ERR_W-2:0] r_sum_neg;
    logic signed [ERR_W-2:0] w_sample;
    logic signed [ERR_W-2:0] w_term;
    logic                    w_half_end;
    logic                    w_period_end;
    logic                    w_acc_en;

    assign w_sample = (ERR_W-1)'(i_adc);
    assign w_term   = w_acc_en ? w_sample : '0;

    fog_mod_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_state      (r_state),
        .i_freq_cnt   (i_freq_cnt),
        .i_wait_cnt   (i_wait_cnt),
        .o_half_end   (w_half_end),
        .o_period_end (w_period_end),
        .o_acc_en     (w_acc_en),
`ifdef FOG_DEMOD_MONITOR_EN
        .o_cnt        (m_cnt)
`else
        .o_cnt        ()
`endif
    );

    // Dropping i_en outranks everything, including a pending period-end strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_sum_pos    <= '0;
            r_sum_neg    <= '0;
            o_mod_stat   <= 1'b0;
            o_err        <= '0;
            o_err_strobe <= 1'b0;
        end else if (!i_en) begin
            r_state      <= S_IDLE;
            r_sum_pos    <= '0;
            r_sum_neg    <= '0;
            o_mod_stat   <= 1'b0;
            o_err_strobe <= 1'b0;
        end else begin
            o_err_strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_POS;
                    r_sum_pos  <= '0;
                    r_sum_neg  <= '0;
                    o_mod_stat <= 1'b1;
                end
                S_POS: begin
                    if (w_acc_en) r_sum_pos <= r_sum_pos + w_sample;
                    if (w_half_end) begin
                        r_state    <= S_NEG;
                        o_mod_stat <= 1'b0;
                    end
                end
                S_NEG: begin
                    if (w_period_end) begin
                        o_err        <= ERR_W'(r_sum_pos) - (ERR_W'(r_sum_neg) + ERR_W'(w_term));
                        o_err_strobe <= 1'b1;
                        r_sum_pos    <= '0;
                        r_sum_neg    <= '0;
                        r_state      <= S_POS;
                        o_mod_stat   <= 1'b1;
                    end else if (w_acc_en) begin
                        r_sum_neg <= r_sum_neg + w_sample;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    o_mod_stat <= 1'b0;
                end
            endcase
        end
    end

`ifdef FOG_DEMOD_MONITOR_EN
    assign m_state   = r_state;
    assign m_sum_pos = ERR_W'(r_sum_pos);
    assign m_sum_neg = ERR_W'(r_sum_neg);
`endif

endmodule

// File: tb/tb_fog_demod_accum.sv
// Scoreboard bench for fog_demod_accum: expected strobe cycle and error word
// are queued from the stimulus plan and popped whenever the DUT strobes.
module tb_fog_demod_accum;

    localparam int ADC_W = 14;
    localparam int CNT_W = 16;
    localparam int ERR_W = 32;

    typedef struct {
        int     cyc;
        longint err;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en  = 1'b0;
    logic [CNT_W-1:0]        freq_cnt = '0;
    logic [CNT_W-1:0]        wait_cnt = '0;
    logic signed [ADC_W-1:0] adc = '0;
    logic                    mod_stat;
    logic signed [ERR_W-1:0] err;
    logic                    err_strobe;

    exp_t   sb_q[$];
    int     cyc = 0;
    int     n_chk = 0;
    int     n_err = 0;
    longint last_err = 0;

    fog_demod_accum #(
        .ADC_W (ADC_W),
        .CNT_W (CNT_W),
        .ERR_W (ERR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_freq_cnt   (freq_cnt),
        .i_wait_cnt   (wait_cnt),
        .i_adc        (adc),
        .o_mod_stat   (mod_stat),
        .o_err        (err),
        .o_err_strobe (err_strobe)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && err_strobe) begin
            if (sb_q.size() == 0) begin
                check("spurious_strobe", err_strobe, 1'b0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("strobe_cycle", cyc, e.cyc);
                check("err", err, e.err);
            end
        end
    end

    function automatic int clamp_f(input int f);
        return (f < 2) ? 2 : f;
    endfunction

    // Runs nper periods from IDLE; adc follows the bench's own phase plan.
    // chg_at >= 0 rewrites i_freq_cnt that many cycles after enable.
    // abort drops i_en on the last period-end cycle instead of letting it strobe.
    task automatic run(input int f, input int w, input int pos, input int neg, input int nper,
                       input int chg_at, input int chg_f, input bit abort);
        int st[];
        int ff[];
        int e0, k, off, endc, ns;
        st = new[nper + 1];
        ff = new[nper];
        e0 = cyc + 1;
        st[0] = e0;
        for (int p = 0; p < nper; p++) begin
            ff[p] = (p == 0 || chg_at < 0) ? clamp_f(f) : clamp_f(chg_f);
            st[p + 1] = st[p] + 2 * ff[p];
            ns = (ff[p] > w) ? ff[p] - w : 0;
            if (!(abort && p == nper - 1)) begin
                sb_q.push_back('{cyc: st[p + 1], err: longint'(ns) * (pos - neg)});
                last_err = longint'(ns) * (pos - neg);
            end
        end
        freq_cnt = CNT_W'(f);
        wait_cnt = CNT_W'(w);
        adc      = '0;
        en       = 1'b1;
        k        = 0;
        endc     = abort ? st[nper] - 1 : st[nper];
        while (cyc < endc) begin
            @(negedge clk);
            if (k < nper - 1 && cyc >= st[k + 1]) k++;
            off = cyc - st[k];
            if (off < 2 * ff[k]) check("mod_stat", mod_stat, (off < ff[k]) ? 1 : 0);
            adc = ADC_W'((off < ff[k]) ? pos : neg);
            if (chg_at >= 0 && cyc == e0 - 1 + chg_at) freq_cnt = CNT_W'(chg_f);
        end
        en = 1'b0;
        @(negedge clk);
        check("mod_idle", mod_stat, 1'b0);
        if (abort) check("err_hold", err, last_err);
        @(negedge clk);
        check("missing_strobe", sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_mod", mod_stat, 1'b0);
        check("rst_err", err, 0);
        check("rst_strobe", err_strobe, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run(8, 2, 100, 100, 3, -1, 0, 1'b0);
        run(8, 2, 100, -100, 2, -1, 0, 1'b0);
        run(8, 8, 100, -100, 2, -1, 0, 1'b0);
        run(8, 10, 100, -100, 1, -1, 0, 1'b0);
        run(0, 0, 100, -100, 3, -1, 0, 1'b0);
        run(8, 2, 50, -30, 3, 3, 4, 1'b0);
        run(8, 2, 70, -10, 2, -1, 0, 1'b1);

        // Asynchronous reset in the middle of a negative half.
        freq_cnt = 16'd8;
        wait_cnt = 16'd2;
        adc      = 14'sd100;
        en       = 1'b1;
        repeat (12) @(negedge clk);
        check("pre_rst_neg", mod_stat, 1'b0);
        check("pre_rst_err", err, last_err);
        rst = 1'b1;
        #1;
        check("arst_mod", mod_stat, 1'b0);
        check("arst_err", err, 0);
        check("arst_strobe", err_strobe, 1'b0);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run(20000, 0, 8191, -8192, 1, -1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
